// File: rtl/byte_deserializer.sv
// Serial-to-parallel front end: aligns on SOF, packs 8 serial bits into a held byte bus,
// and reports mid-byte SOFs and a running count of delivered bytes.
module byte_deserializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin_valid,
  input  logic       sin_bit,
  input  logic       sin_sof,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic [7:0] byte_cnt,
  output logic       busy
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e      state_q;
  logic [2:0]  idx_q;
  logic [7:0]  sreg_q;
  logic [7:0]  data_q;
  logic        dv_q;
  logic        fe_q;
  logic [7:0]  cnt_q;
  logic        busy_q;

  logic [2:0]  pos;
  logic [2:0]  sof_pos;
  logic [7:0]  byte_ins;
  logic [7:0]  byte_sof;

  // byte_ins: partial byte with the current bit merged; byte_sof: fresh byte started by SOF.
  always_comb begin
    pos      = MSB_FIRST ? (3'd7 - idx_q) : idx_q;
    sof_pos  = MSB_FIRST ? 3'd7 : 3'd0;
    byte_ins = sreg_q;
    byte_ins[pos] = sin_bit;
    byte_sof = 8'h00;
    byte_sof[sof_pos] = sin_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      sreg_q  <= 8'h00;
      data_q  <= 8'h00;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      cnt_q   <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      fe_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sin_valid && sin_sof) begin
            state_q <= StShift;
            sreg_q  <= byte_sof;
            idx_q   <= 3'd1;
            busy_q  <= 1'b1;
          end
        end
        StShift: begin
          if (sin_valid) begin
            if (sin_sof) begin
              // Any SOF not on index 0 abandons the partial byte, including at index 7.
              fe_q   <= (idx_q != 3'd0);
              sreg_q <= byte_sof;
              idx_q  <= 3'd1;
              busy_q <= 1'b1;
            end else begin
              sreg_q <= byte_ins;
              idx_q  <= idx_q + 3'd1;
              busy_q <= (idx_q != 3'd7);
              if (idx_q == 3'd7) begin
                data_q <= byte_ins;
                dv_q   <= 1'b1;
                cnt_q  <= cnt_q + 8'd1;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign byte_cnt   = cnt_q;
  assign busy       = busy_q;

endmodule
